// File: rtl/ann_ctrl_pkg.sv
// ann_ctrl_pkg: shared state encoding and per-layer constants for the ANN layer controllers
package ann_ctrl_pkg;
    localparam int DW = 16;
    localparam int L1_DEPTH = 28;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} seq_state_e;
endpackage

// File: rtl/weight_skid_buffer.sv
// weight_skid_buffer: 2-entry valid/ready buffer (output register plus skid) exposing its occupancy
module weight_skid_buffer #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);
    logic [1:0]   occ_q, occ_d, keep;
    logic [W-1:0] head_q, head_d, skid_q, skid_d;
    logic         pop;
    always_comb begin
        pop    = (occ_q != 2'd0) && out_ready;
        keep   = occ_q - {1'b0, pop};
        occ_d  = keep + {1'b0, in_valid};
        // a new word lands in the first slot left free after this cycle's pop
        head_d = (in_valid && keep == 2'd0) ? in_data : (pop ? skid_q : head_q);
        skid_d = (in_valid && keep == 2'd1) ? in_data : skid_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end
    assign out_valid = occ_q != 2'd0;
    assign out_data  = head_q;
    assign occ       = occ_q;
endmodule

// File: rtl/weight_row_sequencer.sv
// weight_row_sequencer: arbitrates one weight BRAM between a host row loader and a backpressured row streamer
module weight_row_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int DEPTH = L1_DEPTH,
    parameter int AW    = 5,
    parameter int DW    = ann_ctrl_pkg::DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          LOAD_START,
    input  logic          LOAD_VALID,
    input  logic [DW-1:0] LOAD_DATA,
    output logic          LOAD_READY,
    output logic          W_VALID,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_INDEX,
    output logic          W_LAST,
    input  logic          W_READY,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] BRAM_ADDR,
    output logic [DW-1:0] BRAM_DI,
    output logic          BRAM_EN,
    output logic          BRAM_WE,
    input  logic [DW-1:0] BRAM_DO
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic             done_q, done_d, pop, issue, wr;
    logic [1:0]       occ, keep;
    logic [DW+AW:0]   buf_out;

    // BRAM_DO is valid at the edge closing the issue cycle, so the buffer captures it directly
    weight_skid_buffer #(.W(DW + AW + 1)) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (issue),
        .in_data   ({BRAM_DO, rcnt_q, rcnt_q == LAST}),
        .out_ready (W_READY),
        .out_valid (W_VALID),
        .out_data  (buf_out),
        .occ       (occ)
    );
    assign {W_DATA, W_INDEX, W_LAST} = buf_out;

    always_comb begin
        pop     = W_VALID && W_READY;
        keep    = occ - {1'b0, pop};
        wr      = !RST && state_q == LOAD && LOAD_VALID;
        issue   = !RST && state_q == STREAM && keep != 2'd2;
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                wcnt_d  = '0;
                rcnt_d  = '0;
                state_d = LOAD_START ? LOAD : (START ? STREAM : IDLE);
            end
            LOAD: if (wr) begin
                state_d = (wcnt_q == LAST) ? IDLE : LOAD;
                done_d  = wcnt_q == LAST;
                wcnt_d  = (wcnt_q == LAST) ? '0 : wcnt_q + 1'b1;
            end
            STREAM: if (issue) begin
                state_d = (rcnt_q == LAST) ? DRAIN : STREAM;
                rcnt_d  = (rcnt_q == LAST) ? rcnt_q : rcnt_q + 1'b1;
            end
            DRAIN: if (keep == 2'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
                rcnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
        end
    end

    assign BRAM_EN    = wr || issue;
    assign BRAM_WE    = wr;
    assign BRAM_ADDR  = (state_q == LOAD) ? wcnt_q : rcnt_q;
    assign BRAM_DI    = (state_q == LOAD) ? LOAD_DATA : '0;
    assign LOAD_READY = state_q == LOAD;
    assign BUSY       = state_q != IDLE;
    assign DONE       = done_q;
endmodule

// File: tb/tb_weight_row_sequencer.sv
// tb_weight_row_sequencer: randomized scoreboard bench with a behavioural BRAM and row reference model
module tb_weight_row_sequencer;
    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          LOAD_START = 1'b0;
    logic          LOAD_VALID = 1'b0;
    logic [DW-1:0] LOAD_DATA = '0;
    logic          W_READY;
    logic [DW-1:0] BRAM_DO = '0;
    logic          LOAD_READY, W_VALID, W_LAST, BUSY, DONE, BRAM_EN, BRAM_WE;
    logic [DW-1:0] W_DATA, BRAM_DI;
    logic [AW-1:0] W_INDEX, BRAM_ADDR;

    weight_row_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LOAD_START(LOAD_START),
        .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .LOAD_READY(LOAD_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_INDEX(W_INDEX), .W_LAST(W_LAST),
        .W_READY(W_READY), .BUSY(BUSY), .DONE(DONE), .BRAM_ADDR(BRAM_ADDR),
        .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int rmode = 0;
    int rd_cnt = 0;
    int xf_cnt = 0;
    bit stream_on = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW+AW:0]  held;
    logic [DW+AW:0]  exp_q[$];
    logic [DW+AW-1:0] wq[$];
    logic [DW-1:0]   ref_mem [DEPTH];
    logic [DW-1:0]   mem [32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // falling-edge BRAM: read data is on BRAM_DO by the next rising edge
    always @(negedge CLK) begin
        if (BRAM_EN && BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
        if (BRAM_EN && !BRAM_WE) BRAM_DO <= mem[BRAM_ADDR];
    end

    initial begin
        int ph;
        ph = 0;
        W_READY = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            ph++;
            case (rmode)
                0: W_READY = 1'b1;
                1: W_READY = (ph % 4 == 0) || (ph % 4 == 3);
                2: W_READY = 1'($urandom_range(0, 1));
                default: W_READY = ($urandom_range(0, 9) == 0);
            endcase
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            chk("bram_en_in_reset", 64'(BRAM_EN), 64'(0));
            exp_q.delete();
            rd_cnt = 0;
            xf_cnt = 0;
            stall_prev = 1'b0;
        end else begin
            if (BRAM_EN && BRAM_WE) begin
                chk("write_only_in_load", 64'(LOAD_READY), 64'(1));
                if (wq.size() == 0) chk("unexpected_write", 64'({BRAM_ADDR, BRAM_DI}), 64'(0));
                else chk("write_addr_data", 64'({BRAM_ADDR, BRAM_DI}), 64'(wq.pop_front()));
            end
            if (BRAM_EN && !BRAM_WE) begin
                rd_cnt++;
                chk("read_allowed_in_bound", 64'(stream_on && BRAM_ADDR <= 27), 64'(1));
            end
            if (stall_prev) chk("stall_hold", 64'({W_VALID, W_DATA, W_INDEX, W_LAST}), 64'({1'b1, held}));
            if (W_VALID && W_READY) begin
                xf_cnt++;
                if (exp_q.size() == 0) chk("unexpected_word", 64'({W_DATA, W_INDEX, W_LAST}), 64'(0));
                else chk("stream_word", 64'({W_DATA, W_INDEX, W_LAST}), 64'(exp_q.pop_front()));
            end
            if (BRAM_EN && !BRAM_WE) chk("outstanding_le2", 64'(rd_cnt - xf_cnt <= 2), 64'(1));
            stall_prev = W_VALID && !W_READY;
            held = {W_DATA, W_INDEX, W_LAST};
        end
    end

    task automatic chk_idle_zero();
        chk("zero_w_valid", 64'(W_VALID), 64'(0));
        chk("zero_w_data", 64'(W_DATA), 64'(0));
        chk("zero_w_index", 64'(W_INDEX), 64'(0));
        chk("zero_w_last", 64'(W_LAST), 64'(0));
        chk("zero_busy", 64'(BUSY), 64'(0));
        chk("zero_done", 64'(DONE), 64'(0));
        chk("zero_load_ready", 64'(LOAD_READY), 64'(0));
        chk("zero_bram_en", 64'(BRAM_EN), 64'(0));
        chk("zero_bram_we", 64'(BRAM_WE), 64'(0));
        chk("zero_bram_addr", 64'(BRAM_ADDR), 64'(0));
        chk("zero_bram_di", 64'(BRAM_DI), 64'(0));
    endtask

    task automatic load_row(input int gap, input bit inc, input bit coll);
        logic [DW-1:0] w;
        LOAD_START = 1'b1;
        START = coll;
        @(posedge CLK); #2;
        LOAD_START = 1'b0;
        START = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int g = 0; g < gap; g++) begin
                LOAD_VALID = 1'b0;
                chk("load_ready_gap", 64'(LOAD_READY), 64'(1));
                @(posedge CLK); #2;
            end
            w = inc ? 16'h0100 + 16'(i) : 16'($urandom);
            LOAD_VALID = 1'b1;
            LOAD_DATA = w;
            wq.push_back({AW'(i), w});
            ref_mem[i] = w;
            chk("load_ready", 64'(LOAD_READY), 64'(1));
            START = coll && (i == 5);
            @(posedge CLK); #2;
            START = 1'b0;
        end
        LOAD_VALID = 1'b0;
        chk("load_done", 64'(DONE), 64'(1));
        chk("load_idle_after", 64'(BUSY), 64'(0));
        chk("load_all_writes", 64'(wq.size()), 64'(0));
        @(posedge CLK); #2;
        chk("load_done_pulse", 64'(DONE), 64'(0));
        chk("load_start_dropped", 64'(BUSY), 64'(0));
    endtask

    task automatic stream_row(input int mode, input int rst_after);
        int cyc, first_v, last_c, done_c, base;
        rmode = mode;
        @(posedge CLK); #2;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ref_mem[i], AW'(i), i == DEPTH - 1});
        stream_on = 1'b1;
        base = xf_cnt;
        first_v = -1;
        last_c = -1;
        done_c = -1;
        START = 1'b1;
        @(posedge CLK); #2;
        START = 1'b0;
        cyc = 1;
        while (done_c < 0 && cyc < 3000) begin
            if (W_VALID && first_v < 0) first_v = cyc;
            if (W_VALID && W_LAST && last_c < 0) last_c = cyc;
            if (DONE) done_c = cyc;
            if (rst_after >= 0 && xf_cnt - base > rst_after) begin
                RST = 1'b1;
                @(posedge CLK); #2;
                RST = 1'b0;
                chk_idle_zero();
                stream_on = 1'b0;
                return;
            end
            if (done_c < 0) begin
                @(posedge CLK); #2;
                cyc++;
            end
        end
        chk("stream_done_seen", 64'(done_c >= 0), 64'(1));
        if (mode == 0) begin
            chk("first_valid_cycle", 64'(first_v), 64'(2));
            chk("last_cycle", 64'(last_c), 64'(DEPTH + 1));
            chk("done_cycle", 64'(done_c), 64'(DEPTH + 2));
        end
        chk("stream_all_delivered", 64'(exp_q.size()), 64'(0));
        chk("stream_idle", 64'(BUSY), 64'(0));
        @(posedge CLK); #2;
        chk("stream_done_pulse", 64'(DONE), 64'(0));
        stream_on = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #2;
        chk_idle_zero();
        RST = 1'b0;
        @(posedge CLK); #2;
        chk_idle_zero();
        load_row(0, 1'b1, 1'b0);
        stream_row(0, -1);
        stream_row(1, -1);
        load_row(2, 1'b0, 1'b0);
        stream_row(2, -1);
        load_row(0, 1'b0, 1'b1);
        stream_row(0, -1);
        stream_row(0, 10);
        stream_row(0, -1);
        stream_row(3, -1);
        for (int k = 0; k < 3; k++) begin
            load_row(int'($urandom_range(0, 2)), 1'b0, 1'b0);
            stream_row(int'($urandom_range(0, 3)), -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
